// File: rtl/i2s_rx_unit.sv
// -----------------------------------------------------------------------------
// i2s_rx_unit
// I2S receiver. Oversamples the external bit clock, word select and serial
// data in the clk domain, deserializes SAMPLE_WIDTH-bit stereo samples (MSB
// first, one-bit delay after each ws edge) and presents every complete
// left-then-right pair with a one-clock valid strobe. Slots whose length
// differs from SLOT_BITS are flagged with a one-clock error strobe.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   play_in         receiver enable; low forces IDLE
//   sck_in          I2S bit clock (asynchronous to clk)
//   ws_in           I2S word select, 0 = left, 1 = right
//   sdi_in          I2S serial data
//   audio_out_0/1   last left/right sample pair, held until the next valid
//   valid_out       one-clock strobe: new pair on audio_out_0/1
//   frame_err_out   one-clock strobe: slot length violation
//   locked_out      receiver aligned to ws (RUN state)
// -----------------------------------------------------------------------------
module i2s_rx_unit #(
  parameter int SYNC_STAGES  = 2,
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_BITS    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    play_in,
  input  logic                    sck_in,
  input  logic                    ws_in,
  input  logic                    sdi_in,
  output logic [SAMPLE_WIDTH-1:0] audio_out_0,
  output logic [SAMPLE_WIDTH-1:0] audio_out_1,
  output logic                    valid_out,
  output logic                    frame_err_out,
  output logic                    locked_out
);

  localparam int CW = ($clog2(SLOT_BITS) > 5) ? $clog2(SLOT_BITS) : 5;
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);
  localparam logic [CW-1:0] LAST_SLOT_CNT = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] LAST_WORD_CNT = CW'(SAMPLE_WIDTH - 1);
  localparam logic [CW-1:0] WORD_CNT      = CW'(SAMPLE_WIDTH);

  // A word completion must never coincide with a slot boundary.
  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("i2s_rx_unit: SYNC_STAGES must be at least 2");
    end
    if (SAMPLE_WIDTH >= SLOT_BITS) begin : g_bad_sample_width
      $error("i2s_rx_unit: SAMPLE_WIDTH must be smaller than SLOT_BITS");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0]  r_sck_sync;
  logic [SYNC_STAGES-1:0]  r_ws_sync;
  logic [SYNC_STAGES-1:0]  r_sdi_sync;
  logic                    r_sck_dly;
  logic                    r_rise;
  logic                    r_ws_smp;
  logic                    r_sdi_smp;
  logic                    r_ws_q;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic                    r_ch;
  logic [SAMPLE_WIDTH-2:0] r_shreg;
  logic [SAMPLE_WIDTH-1:0] r_left_hold;
  logic                    r_l_ok;

  state_t                  w_state_nxt;
  logic [CW-1:0]           w_cnt_nxt;
  logic                    w_ch_nxt;
  logic [SAMPLE_WIDTH-2:0] w_shreg_nxt;
  logic [SAMPLE_WIDTH-1:0] w_left_nxt;
  logic                    w_l_ok_nxt;
  logic [SAMPLE_WIDTH-1:0] w_aud0_nxt;
  logic [SAMPLE_WIDTH-1:0] w_aud1_nxt;
  logic                    w_valid_nxt;
  logic                    w_err_nxt;
  logic                    w_sck_s;
  logic                    w_boundary;
  logic [SAMPLE_WIDTH-1:0] w_word;

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  // ws differing from its value at the previous rise marks the last bit of a slot.
  assign w_boundary = r_rise & (r_ws_smp ^ r_ws_q);
  assign w_word     = {r_shreg, r_sdi_smp};

  // Synchronize the I2S inputs and register the sck rising-edge strobe with aligned ws/sdi samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sdi_sync <= '0;
      r_sck_dly  <= 1'b0;
      r_rise     <= 1'b0;
      r_ws_smp   <= 1'b0;
      r_sdi_smp  <= 1'b0;
      r_ws_q     <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck_in};
      r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0], ws_in};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi_in};
      r_sck_dly  <= w_sck_s;
      r_rise     <= w_sck_s & ~r_sck_dly;
      r_ws_smp   <= r_ws_sync[SYNC_STAGES-1];
      r_sdi_smp  <= r_sdi_sync[SYNC_STAGES-1];
      // ws_q keeps tracking even while idle so the first boundary after enable is genuine.
      if (r_rise) begin
        r_ws_q <= r_ws_smp;
      end else begin
        r_ws_q <= r_ws_q;
      end
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, slot counter, word assembly and pairing decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ch_nxt    = r_ch;
    w_shreg_nxt = r_shreg;
    w_left_nxt  = r_left_hold;
    w_l_ok_nxt  = r_l_ok;
    w_aud0_nxt  = audio_out_0;
    w_aud1_nxt  = audio_out_1;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    if (!play_in) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_shreg_nxt = '0;
      w_l_ok_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SYNC;
        end
        ST_SYNC: begin
          if (w_boundary) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
            w_ch_nxt    = r_ws_smp;
          end else begin
            w_cnt_nxt = '0;
          end
        end
        ST_RUN: begin
          if (w_boundary) begin
            w_cnt_nxt = '0;
            w_ch_nxt  = r_ws_smp;
            if (r_cnt != LAST_SLOT_CNT) begin
              // Short or long slot: the pair it belongs to is dropped.
              w_err_nxt  = 1'b1;
              w_l_ok_nxt = 1'b0;
            end else begin
              w_err_nxt = 1'b0;
            end
          end else if (r_rise) begin
            if (r_cnt == LAST_SLOT_CNT) begin
              // A full slot elapsed without a ws edge: alignment is lost.
              w_err_nxt   = 1'b1;
              w_l_ok_nxt  = 1'b0;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_SYNC;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
              if (r_cnt < WORD_CNT) begin
                w_shreg_nxt = w_word[SAMPLE_WIDTH-2:0];
              end else begin
                w_shreg_nxt = r_shreg;
              end
              if (r_cnt == LAST_WORD_CNT) begin
                if (!r_ch) begin
                  w_left_nxt = w_word;
                  w_l_ok_nxt = 1'b1;
                end else if (r_l_ok) begin
                  w_aud0_nxt  = r_left_hold;
                  w_aud1_nxt  = w_word;
                  w_valid_nxt = 1'b1;
                  w_l_ok_nxt  = 1'b0;
                end else begin
                  // Right word without a preceding left word is discarded.
                  w_l_ok_nxt = 1'b0;
                end
              end else begin
                w_l_ok_nxt = r_l_ok;
              end
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_ch          <= 1'b0;
      r_shreg       <= '0;
      r_left_hold   <= '0;
      r_l_ok        <= 1'b0;
      audio_out_0   <= '0;
      audio_out_1   <= '0;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
      locked_out    <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_ch          <= w_ch_nxt;
      r_shreg       <= w_shreg_nxt;
      r_left_hold   <= w_left_nxt;
      r_l_ok        <= w_l_ok_nxt;
      audio_out_0   <= w_aud0_nxt;
      audio_out_1   <= w_aud1_nxt;
      valid_out     <= w_valid_nxt;
      frame_err_out <= w_err_nxt;
      locked_out    <= (w_state_nxt == ST_RUN);
    end
  end

endmodule

// File: tb/tb_i2s_rx_unit.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx_unit
// Drives I2S slots (sck = 8 clk periods) into i2s_rx_unit and checks received
// pairs, strobes, lock status and latency against a slot-level model of the
// receiver's rules: a slot either completes a word, locks, errors or unlocks.
// -----------------------------------------------------------------------------
module tb_i2s_rx_unit;

  localparam int SYNC_STAGES  = 2;
  localparam int SAMPLE_WIDTH = 24;
  localparam int SLOT_BITS    = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        play_in;
  logic        sck_in;
  logic        ws_in;
  logic        sdi_in;
  logic [23:0] audio_out_0;
  logic [23:0] audio_out_1;
  logic        valid_out;
  logic        frame_err_out;
  logic        locked_out;

  i2s_rx_unit #(
    .SYNC_STAGES (SYNC_STAGES),
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .SLOT_BITS   (SLOT_BITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .play_in      (play_in),
    .sck_in       (sck_in),
    .ws_in        (ws_in),
    .sdi_in       (sdi_in),
    .audio_out_0  (audio_out_0),
    .audio_out_1  (audio_out_1),
    .valid_out    (valid_out),
    .frame_err_out(frame_err_out),
    .locked_out   (locked_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state
  logic        m_play   = 1'b0;
  logic        m_locked = 1'b0;
  logic        m_l_ok   = 1'b0;
  logic [23:0] m_left   = '0;
  int          m_err    = 0;
  int          m_pairs  = 0;
  logic [47:0] exp_q[$];
  logic [47:0] last_pair = '0;

  // Observations
  int   n_valid = 0;
  int   n_err   = 0;
  int   t_r23   = 0;
  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;

  task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One sck period: ws/sdi change with the falling edge, sampled on the rise.
  task automatic send_bit(input logic ws, input logic d, input logic mark);
    sck_in = 1'b0;
    ws_in  = ws;
    sdi_in = d;
    repeat (4) @(negedge clk);
    sck_in = 1'b1;
    if (mark) t_r23 = cyc;
    repeat (4) @(negedge clk);
  endtask

  // One slot of len bits for channel ch; the last bit already carries nxt on ws.
  task automatic send_slot(input logic ch, input logic [23:0] w, input int len, input logic nxt);
    logic b;
    if (m_play) begin
      if (m_locked) begin
        if (ch == 1'b0) begin
          m_left = w;
          m_l_ok = 1'b1;
        end else if (m_l_ok) begin
          exp_q.push_back({m_left, w});
          m_pairs++;
          m_l_ok = 1'b0;
        end
        if (nxt != ch) begin
          if (len != SLOT_BITS) begin
            m_err++;
            m_l_ok = 1'b0;
          end
        end else if (len > SLOT_BITS) begin
          m_err++;
          m_l_ok   = 1'b0;
          m_locked = 1'b0;
        end
      end else if (nxt != ch) begin
        m_locked = 1'b1;
        m_l_ok   = 1'b0;
      end
    end
    for (int j = 0; j < len; j++) begin
      b = (j < 24) ? w[23-j] : 1'($urandom_range(0, 1));
      send_bit((j == len - 1) ? nxt : ch, b, ch && (j == 23));
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_slot(1'b0, l, SLOT_BITS, 1'b1);
    send_slot(1'b1, r, SLOT_BITS, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_aud0"},   48'(audio_out_0), 48'd0);
    check({tag, "_aud1"},   48'(audio_out_1), 48'd0);
    check({tag, "_valid"},  48'(valid_out), 48'd0);
    check({tag, "_err"},    48'(frame_err_out), 48'd0);
    check({tag, "_locked"}, 48'(locked_out), 48'd0);
  endtask

  task automatic check_status(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_locked"},    48'(locked_out), 48'(m_locked));
    check({tag, "_valid_cnt"}, 48'(n_valid), 48'(m_pairs));
    check({tag, "_err_cnt"},   48'(n_err), 48'(m_err));
  endtask

  // Output monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (valid_out) begin
      n_valid++;
      check("valid_width", 48'(prev_valid), 48'd0);
      check("valid_latency", 48'(cyc - t_r23), 48'(SYNC_STAGES + 2));
      check("pair_expected", 48'(exp_q.size() != 0), 48'd1);
      if (exp_q.size() != 0) begin
        last_pair = exp_q.pop_front();
        check("left",  48'(audio_out_0), 48'(last_pair[47:24]));
        check("right", 48'(audio_out_1), 48'(last_pair[23:0]));
      end
    end
    if (frame_err_out) begin
      n_err++;
      check("err_width", 48'(prev_err), 48'd0);
    end
    prev_valid = valid_out;
    prev_err   = frame_err_out;
  end

  initial begin
    rst     = 1'b1;
    play_in = 1'b0;
    sck_in  = 1'b0;
    ws_in   = 1'b0;
    sdi_in  = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // A valid stream while disabled must produce nothing.
    m_play = 1'b0;
    send_frame(24'h123456, 24'hABCDEF);
    send_frame(24'h654321, 24'h0F0F0F);
    check_status("idle");

    // Basic pair: first frame only aligns.
    play_in = 1'b1;
    m_play  = 1'b1;
    repeat (2) @(negedge clk);
    check("sync_not_locked", 48'(locked_out), 48'd0);
    send_slot(1'b0, 24'h123456, SLOT_BITS, 1'b1);
    check_status("first_ws_edge");
    send_slot(1'b1, 24'hABCDEF, SLOT_BITS, 1'b0);
    check_status("align_frame");
    for (int i = 0; i < 3; i++) send_frame(24'h123456, 24'hABCDEF);
    check_status("basic");

    // Extremes and bit order.
    send_frame(24'h800000, 24'h7FFFFF);
    send_frame(24'h000000, 24'hFFFFFF);
    send_frame(24'h000001, 24'h800001);
    check_status("extremes");

    // Short left slot: its pair is dropped, the next one is delivered.
    send_slot(1'b0, 24'($urandom), 30, 1'b1);
    send_slot(1'b1, 24'($urandom), SLOT_BITS, 1'b0);
    send_frame(24'($urandom), 24'($urandom));
    check_status("short_slot");

    // Stuck ws: lock is lost, then regained.
    send_slot(1'b0, 24'($urandom), 40, 1'b0);
    check_status("stuck_ws");
    for (int i = 0; i < 3; i++) send_frame(24'($urandom), 24'($urandom));
    check_status("relock");

    // Reset in the middle of a slot.
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    rst    = 1'b1;
    sck_in = 1'b0;
    ws_in  = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    m_locked = 1'b0;
    m_l_ok   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(24'($urandom), 24'($urandom));
    send_frame(24'($urandom), 24'($urandom));
    check_status("after_reset");

    // Random loopback-style traffic.
    for (int i = 0; i < 60; i++) send_frame(24'($urandom), 24'($urandom));
    check_status("random");
    check("pending_pairs", 48'(exp_q.size()), 48'd0);
    check("hold_left",  48'(audio_out_0), 48'(last_pair[47:24]));
    check("hold_right", 48'(audio_out_1), 48'(last_pair[23:0]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
